sonar_ctrl: RTL

SONAR_CTRL -- requirements
Module: sonar_ctrl

---
 rtl/sonar_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sonar_ctrl.sv
// Ultrasonic ranging controller: fires a trigger pulse, times the synchronised
// echo, and enforces a minimum trigger-to-trigger period between measurements.
module sonar_ctrl #(
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned TIMEOUT_CYCLES = 1900000,
    parameter int unsigned PERIOD_CYCLES  = 3000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        echo,
    output logic        trig,
    output logic        meas_n,
    output logic        done,
    output logic        timeout,
    output logic        busy,
    output logic [21:0] echo_cycles
);

    localparam int unsigned PH_MAX = (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES;
    localparam int PW = $clog2(PH_MAX + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(PERIOD_CYCLES + 1);

    localparam logic [PW-1:0] TRIG_LAST   = PW'(TRIG_CYCLES - 1);
    localparam logic [PW-1:0] WAIT_LAST   = PW'(TIMEOUT_CYCLES - 1);
    localparam logic [WW-1:0] WIDTH_MAX   = WW'(TIMEOUT_CYCLES);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(PERIOD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_ECHO,
        S_MEASURE,
        S_HOLDOFF
    } state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   phase_cnt, phase_nx, phase_inc;
    logic [WW-1:0]   width_cnt, width_nx, width_inc;
    logic [RW-1:0]   period_cnt, period_nx, period_inc;
    logic            done_nx, timeout_nx;
    logic [21:0]     echo_cycles_nx;

    logic            echo_s1, echo_s2, echo_d;
    logic            echo_rise;

    // NOTE: all state, including the synchroniser, uses non-blocking assignments
    // so every flop samples pre-edge values; the echo pin is only read via echo_s2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            phase_cnt   <= '0;
            width_cnt   <= '0;
            period_cnt  <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            echo_cycles <= '0;
            echo_s1     <= 1'b0;
            echo_s2     <= 1'b0;
            echo_d      <= 1'b0;
        end else begin
            state       <= state_nx;
            phase_cnt   <= phase_nx;
            width_cnt   <= width_nx;
            period_cnt  <= period_nx;
            done        <= done_nx;
            timeout     <= timeout_nx;
            echo_cycles <= echo_cycles_nx;
            echo_s1     <= echo;
            echo_s2     <= echo_s1;
            echo_d      <= echo_s2;
        end
    end

    // Saturating increments: no counter is ever allowed to wrap.
    assign phase_inc  = (&phase_cnt)  ? phase_cnt  : phase_cnt  + 1'b1;
    assign width_inc  = (&width_cnt)  ? width_cnt  : width_cnt  + 1'b1;
    assign period_inc = (&period_cnt) ? period_cnt : period_cnt + 1'b1;

    assign echo_rise = echo_s2 & ~echo_d;

    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    always_comb begin
        state_nx       = state;
        phase_nx       = phase_cnt;
        width_nx       = width_cnt;
        period_nx      = period_inc;
        done_nx        = 1'b0;
        timeout_nx     = 1'b0;
        echo_cycles_nx = echo_cycles;

        trig   = (state == S_TRIG);
        meas_n = (state != S_MEASURE);
        busy   = (state != S_IDLE);

        unique case (state)
            S_IDLE: begin
                period_nx = period_cnt;
                if (start) begin
                    state_nx  = S_TRIG;
                    phase_nx  = '0;
                    period_nx = '0;
                end
            end

            S_TRIG: begin
                if (phase_cnt == TRIG_LAST) begin
                    state_nx = S_WAIT_ECHO;
                    phase_nx = '0;
                end else begin
                    phase_nx = phase_inc;
                end
            end

            S_WAIT_ECHO: begin
                // The first cycle is masked so an echo already high on entry never counts.
                if ((phase_cnt != '0) && echo_rise) begin
                    state_nx = S_MEASURE;
                    width_nx = WW'(1);
                end else if (phase_cnt == WAIT_LAST) begin
                    state_nx   = S_HOLDOFF;
                    timeout_nx = 1'b1;
                end else begin
                    phase_nx = phase_inc;
                end
            end

            S_MEASURE: begin
                if (!echo_s2) begin
                    state_nx       = S_HOLDOFF;
                    done_nx        = 1'b1;
                    echo_cycles_nx = 22'(width_cnt);
                end else if (width_cnt == WIDTH_MAX) begin
                    state_nx   = S_HOLDOFF;
                    timeout_nx = 1'b1;
                end else begin
                    width_nx = width_inc;
                end
            end

            S_HOLDOFF: begin
                // Leaving as the counter lands on PERIOD-1 lets IDLE->TRIG close the period exactly.
                if ((period_inc >= PERIOD_LAST) && !echo_s2) begin
                    state_nx = S_IDLE;
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule
